// File: rtl/psum_accumulator.sv
// Accumulates K-tile partial-sum vectors plus a bias vector into one output tile per reduction.
// Optional lane saturation is enabled by defining PSUM_ACC_SAT_EN; otherwise lanes wrap.
module psum_accumulator #(
    parameter int unsigned SIZE       = 16,
    parameter int unsigned VLEN       = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         init_cfg,
    input  logic [REG_WIDTH-1:0]         k,
    input  logic                         psum_valid,
    output logic                         psum_ready,
    input  logic [DATA_WIDTH*SIZE-1:0]   psum_in,
    input  logic                         bias_valid,
    input  logic [DATA_WIDTH*SIZE-1:0]   bias_in,
    output logic                         partial_sum_calc_over,
    output logic                         tile_calc_over,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH*SIZE-1:0]   data_out,
    output logic                         sat_flag
);

    localparam int unsigned VecW = DATA_WIDTH * SIZE;
    localparam logic [REG_WIDTH-1:0] VLenW = REG_WIDTH'(VLEN);

    typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

    state_e                 state_q, state_d;
    logic [REG_WIDTH-1:0]   num_k_q, num_k_d;
    logic [REG_WIDTH-1:0]   k_cnt_q, k_cnt_d;
    logic [VecW-1:0]        acc_q, acc_d;
    logic                   psc_q, psc_d;
    logic                   tile_q, tile_d;
    logic [VecW-1:0]        sum_vec;
    logic                   any_sat;
    logic [REG_WIDTH-1:0]   num_k_cfg;
    logic                   fire;

    // ceil(k / VLEN) without risking overflow of k + VLEN - 1
    assign num_k_cfg = (k / VLenW) + {{(REG_WIDTH-1){1'b0}}, ((k % VLenW) != '0)};

    assign psum_ready = (state_q == StAcc) && !init_cfg && ((k_cnt_q != '0) || bias_valid);
    assign fire       = psum_valid && psum_ready;
    assign out_valid  = (state_q == StOut);
    assign data_out   = acc_q;
    assign partial_sum_calc_over = psc_q;
    assign tile_calc_over        = tile_q;

    always_comb begin
        logic [DATA_WIDTH-1:0] base;
        logic [DATA_WIDTH-1:0] lane;
`ifdef PSUM_ACC_SAT_EN
        logic [DATA_WIDTH:0]   wide;
        wide = '0;
`endif
        sum_vec = '0;
        any_sat = 1'b0;
        base    = '0;
        lane    = '0;
        for (int i = 0; i < SIZE; i++) begin
            // First beat of a tile seeds the lane with bias instead of the running sum
            base = (k_cnt_q == '0) ? bias_in[i*DATA_WIDTH +: DATA_WIDTH]
                                   : acc_q[i*DATA_WIDTH +: DATA_WIDTH];
            lane = psum_in[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef PSUM_ACC_SAT_EN
            wide = {base[DATA_WIDTH-1], base} + {lane[DATA_WIDTH-1], lane};
            if (wide[DATA_WIDTH] != wide[DATA_WIDTH-1]) begin
                any_sat = 1'b1;
                sum_vec[i*DATA_WIDTH +: DATA_WIDTH] =
                    wide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end else begin
                sum_vec[i*DATA_WIDTH +: DATA_WIDTH] = wide[DATA_WIDTH-1:0];
            end
`else
            sum_vec[i*DATA_WIDTH +: DATA_WIDTH] = base + lane;
`endif
        end
    end

`ifdef PSUM_ACC_SAT_EN
    logic sat_q, sat_d;
    assign sat_flag = sat_q;

    always_comb begin
        sat_d = sat_q;
        if (init_cfg) begin
            sat_d = 1'b0;
        end else if (fire && any_sat) begin
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end
`else
    assign sat_flag = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        num_k_d = num_k_q;
        k_cnt_d = k_cnt_q;
        acc_d   = acc_q;
        psc_d   = 1'b0;
        tile_d  = 1'b0;
        if (init_cfg) begin
            num_k_d = num_k_cfg;
            k_cnt_d = '0;
            acc_d   = '0;
            state_d = (num_k_cfg != '0) ? StAcc : StIdle;
        end else begin
            unique case (state_q)
                StAcc: begin
                    if (fire) begin
                        acc_d   = sum_vec;
                        k_cnt_d = k_cnt_q + REG_WIDTH'(1);
                        psc_d   = 1'b1;
                        if (k_cnt_q + REG_WIDTH'(1) == num_k_q) begin
                            state_d = StOut;
                        end
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        state_d = StAcc;
                        k_cnt_d = '0;
                        acc_d   = '0;
                        tile_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            num_k_q <= '0;
            k_cnt_q <= '0;
            acc_q   <= '0;
            psc_q   <= 1'b0;
            tile_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_k_q <= num_k_d;
            k_cnt_q <= k_cnt_d;
            acc_q   <= acc_d;
            psc_q   <= psc_d;
            tile_q  <= tile_d;
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: tile accumulation, stalls, aborts, wrap/saturation, reset.
module tb_psum_accumulator;

    localparam int unsigned SIZE = 16;
    localparam int unsigned DW   = 32;
    localparam int unsigned VW   = SIZE * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          init_cfg;
    logic [31:0]   k;
    logic          psum_valid;
    logic          psum_ready;
    logic [VW-1:0] psum_in;
    logic          bias_valid;
    logic [VW-1:0] bias_in;
    logic          partial_sum_calc_over;
    logic          tile_calc_over;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] data_out;
    logic          sat_flag;

    int n_vec = 0;
    int n_err = 0;

    psum_accumulator #(
        .SIZE(SIZE), .VLEN(16), .DATA_WIDTH(DW), .REG_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_cfg(init_cfg), .k(k),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_in(psum_in),
        .bias_valid(bias_valid), .bias_in(bias_in),
        .partial_sum_calc_over(partial_sum_calc_over), .tile_calc_over(tile_calc_over),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] fill(input logic [DW-1:0] v);
        logic [VW-1:0] r;
        for (int i = 0; i < SIZE; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic rdy, input logic ov,
                           input logic pc, input logic tc);
        chk({tag, ".psum_ready"}, VW'(psum_ready), VW'(rdy));
        chk({tag, ".out_valid"},  VW'(out_valid),  VW'(ov));
        chk({tag, ".psc_over"},   VW'(partial_sum_calc_over), VW'(pc));
        chk({tag, ".tile_over"},  VW'(tile_calc_over), VW'(tc));
    endtask

    logic [VW-1:0] sat_exp;
    logic          sat_flag_exp;

    initial begin
        rst_n = 1'b0; init_cfg = 1'b0; k = '0; psum_valid = 1'b0; psum_in = '0;
        bias_valid = 1'b0; bias_in = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.data_out", data_out, '0);
        chk("reset.sat_flag", VW'(sat_flag), '0);
        rst_n = 1'b1;

        // k=32 -> two beats; bias 5, psums 1 then 2 -> 8 per lane
        @(negedge clk); init_cfg = 1'b1; k = 32;
        @(negedge clk); init_cfg = 1'b0;
        bias_valid = 1'b1; bias_in = fill(5); psum_valid = 1'b1; psum_in = fill(1);
        #1 chk("t1.ready_b0", VW'(psum_ready), VW'(1'b1));
        @(negedge clk);
        chk_ctl("t1.after_b0", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t1.acc_b0", data_out, fill(6));
        psum_in = fill(2); bias_valid = 1'b0;
        #1 chk("t1.ready_b1_nobias", VW'(psum_ready), VW'(1'b1));
        @(negedge clk);
        chk_ctl("t1.after_b1", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t1.data_out", data_out, fill(8));
        // Output held back for 10 cycles while the array keeps offering beats
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk_ctl("t1.hold", 1'b0, 1'b1, 1'b0, 1'b0);
            chk("t1.hold.data", data_out, fill(8));
        end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        chk_ctl("t1.consumed", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1.acc_cleared", data_out, '0);
        @(negedge clk);
        chk("t1.tile_single", VW'(tile_calc_over), '0);

        // Back in ACC at k_cnt=0: no bias means the first beat must stall
        psum_in = fill(3);
        for (int c = 0; c < 3; c++) begin
            #1 chk("t2.stall_ready", VW'(psum_ready), '0);
            @(negedge clk);
            chk("t2.stall_psc", VW'(partial_sum_calc_over), '0);
            chk("t2.stall_acc", data_out, '0);
        end
        bias_valid = 1'b1; bias_in = fill(32'd10);
        #1 chk("t2.bias_ready", VW'(psum_ready), VW'(1'b1));
        @(negedge clk);
        chk("t2.accepted_psc", VW'(partial_sum_calc_over), VW'(1'b1));
        chk("t2.acc", data_out, fill(13));

        // init_cfg coinciding with an offered beat mid-tile aborts and drops it
        init_cfg = 1'b1; k = 48;
        #1 chk("t3.ready_during_init", VW'(psum_ready), '0);
        @(negedge clk); init_cfg = 1'b0; psum_valid = 1'b0;
        chk("t3.no_psc", VW'(partial_sum_calc_over), '0);
        chk("t3.acc_cleared", data_out, '0);
        chk("t3.out_valid", VW'(out_valid), '0);

        // k=17 -> ceil = 2 beats; lane 0 overflows, other lanes sum to 2
        init_cfg = 1'b1; k = 17;
        @(negedge clk); init_cfg = 1'b0;
        bias_valid = 1'b1; bias_in = '0; psum_valid = 1'b1;
        psum_in = fill(1); psum_in[DW-1:0] = 32'h7FFF_FFFF;
        @(negedge clk);
        chk_ctl("t4.after_b0", 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk); psum_valid = 1'b0;
        sat_exp = fill(2);
`ifdef PSUM_ACC_SAT_EN
        sat_exp[DW-1:0] = 32'h7FFF_FFFF; sat_flag_exp = 1'b1;
`else
        sat_exp[DW-1:0] = 32'hFFFF_FFFE; sat_flag_exp = 1'b0;
`endif
        chk_ctl("t4.after_b1", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4.data_out", data_out, sat_exp);
        chk("t4.sat_flag", VW'(sat_flag), VW'(sat_flag_exp));
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        chk("t4.sat_sticky", VW'(sat_flag), VW'(sat_flag_exp));
        init_cfg = 1'b1; k = 16;
        @(negedge clk); init_cfg = 1'b0;
        chk("t4.sat_cleared", VW'(sat_flag), '0);

        // k=0 keeps the block idle no matter what the array offers
        init_cfg = 1'b1; k = 0;
        @(negedge clk); init_cfg = 1'b0; psum_valid = 1'b1; bias_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1 chk_ctl("t5.k0", 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b0;

        // Reset mid-tile discards the partial accumulation without pulses
        init_cfg = 1'b1; k = 32;
        @(negedge clk); init_cfg = 1'b0; psum_in = fill(7); bias_in = fill(1);
        @(negedge clk); psum_valid = 1'b0;
        chk("t6.acc_mid", data_out, fill(8));
        #1 rst_n = 1'b0;
        #1 chk("t6.async_clear", data_out, '0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk_ctl("t6.post_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6.post_reset.data", data_out, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
